// File: rtl/freq_div_pkg.sv
// Shared constants and the divisor clamp rule for the freq_div family.
package freq_div_pkg;

  // Smallest divisor that still produces a distinct tick and square wave.
  localparam int DIV_MIN = 2;

  // Default widths and divisors used by the BCD and 1-second time-base tops.
  localparam int BCD_CNT_WIDTH = 4;
  localparam int BCD_DIV       = 10;
  localparam int SEC_CNT_WIDTH = 27;
  localparam int SEC_DIV       = 100_000_000;

  // Divisors 0 and 1 are promoted to DIV_MIN; everything else passes through.
  function automatic logic [31:0] clamp_div(input logic [31:0] x);
    return (x < 32'(DIV_MIN)) ? 32'(DIV_MIN) : x;
  endfunction

endpackage

// File: rtl/freq_div_core.sv
// Modulo-N counter with terminal-count detect and a registered tick.
module freq_div_core
  import freq_div_pkg::*;
#(
  parameter int CNT_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 clr,
  input  logic [CNT_WIDTH-1:0] divisor,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 wrap,
  output logic                 tick
);

  // A wrap edge is an enabled, uncleared edge taken from the terminal count.
  assign wrap = en && !clr && (count == divisor - CNT_WIDTH'(1));

  // Counter advances on enable, returns to 0 after divisor-1; tick marks the wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (clr) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (en) begin
      count <= wrap ? '0 : count + CNT_WIDTH'(1);
      tick  <= wrap;
    end else begin
      tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/freq_div_param.sv
// Run-time programmable clock-enable divider: count, tick and square wave,
// with a divisor that is reloaded only at period boundaries.
module freq_div_param
  import freq_div_pkg::*;
#(
  parameter int CNT_WIDTH   = 3,
  parameter int DIV_DEFAULT = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 clr,
  input  logic                 div_load,
  input  logic [CNT_WIDTH-1:0] div_val,
  output logic [CNT_WIDTH-1:0] out,
  output logic                 tick,
  output logic                 sq_out,
  output logic [CNT_WIDTH-1:0] div_active
);

  if (CNT_WIDTH < 2 || CNT_WIDTH > 32) begin : g_bad_width
    $error("freq_div_param: CNT_WIDTH must be in 2..32");
  end
  if (DIV_DEFAULT < DIV_MIN ||
      longint'(DIV_DEFAULT) > ((longint'(1) << CNT_WIDTH) - 1)) begin : g_bad_default
    $error("freq_div_param: DIV_DEFAULT out of range for CNT_WIDTH");
  end

  localparam logic [CNT_WIDTH-1:0] DIV_RST = CNT_WIDTH'(clamp_div(32'(DIV_DEFAULT)));

  function automatic logic [CNT_WIDTH-1:0] sat_div(input logic [CNT_WIDTH-1:0] x);
    return CNT_WIDTH'(clamp_div(32'(x)));
  endfunction

  logic [CNT_WIDTH-1:0] pending;
  logic [CNT_WIDTH-1:0] load_val;
  logic [CNT_WIDTH-1:0] next_div;
  logic [CNT_WIDTH-1:0] half_m1;
  logic                 wrap;

  // A load coinciding with a wrap or clear bypasses pending and takes effect at once.
  assign load_val = sat_div(div_val);
  assign next_div = div_load ? load_val : pending;
  assign half_m1  = (div_active >> 1) - CNT_WIDTH'(1);

  freq_div_core #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .clr     (clr),
    .divisor (div_active),
    .count   (out),
    .wrap    (wrap),
    .tick    (tick)
  );

  // Pending/active divisor registers; active only changes at a wrap or clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending    <= DIV_RST;
      div_active <= DIV_RST;
    end else begin
      if (div_load) pending <= load_val;
      if (clr || wrap) div_active <= next_div;
    end
  end

  // Square wave: set on wrap, cleared after floor(N/2) enabled counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sq_out <= 1'b0;
    end else if (clr) begin
      sq_out <= 1'b0;
    end else if (wrap) begin
      sq_out <= 1'b1;
    end else if (en && (out == half_m1)) begin
      sq_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_freq_div_param.sv
// Directed bench for freq_div_param with a period-level reference model.
module tb_freq_div_param;

  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         clr = 1'b0;
  logic         div_load = 1'b0;
  logic [W-1:0] div_val = '0;
  logic [W-1:0] out;
  logic         tick;
  logic         sq_out;
  logic [W-1:0] div_active;

  freq_div_param #(
    .CNT_WIDTH   (W),
    .DIV_DEFAULT (5)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .clr        (clr),
    .div_load   (div_load),
    .div_val    (div_val),
    .out        (out),
    .tick       (tick),
    .sq_out     (sq_out),
    .div_active (div_active)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  // Model state: position within the period, divisor in use, queued divisor,
  // whether the last edge closed a period, and whether any period has closed
  // since reset/clear (the square wave only starts on the first wrap).
  int m_p = 0;
  int m_n = 5;
  int m_pend = 5;
  int m_tk = 0;
  bit m_seen = 1'b0;

  int t1_out [10] = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0};
  int t1_tick[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
  int t1_sq  [10] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 1};

  function automatic int clamp_m(int x);
    return (x < 2) ? 2 : x;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk or negedge rst_n) begin
    int ld;
    if (!rst_n) begin
      m_p = 0; m_n = 5; m_pend = 5; m_tk = 0; m_seen = 1'b0;
    end else begin
      ld = clamp_m(int'(div_val));
      if (clr) begin
        m_p = 0; m_tk = 0; m_seen = 1'b0;
        m_n = div_load ? ld : m_pend;
      end else if (en) begin
        if (m_p == m_n - 1) begin
          m_p = 0; m_tk = 1; m_seen = 1'b1;
          m_n = div_load ? ld : m_pend;
        end else begin
          m_p = m_p + 1; m_tk = 0;
        end
      end else begin
        m_tk = 0;
      end
      if (div_load) m_pend = ld;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("out", int'(out), m_p);
      chk("tick", int'(tick), m_tk);
      chk("sq_out", int'(sq_out), (m_seen && (m_p < m_n / 2)) ? 1 : 0);
      chk("div_active", int'(div_active), m_n);
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    chk_on = 1'b1;
    chk("rst_out", int'(out), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_sq", int'(sq_out), 0);
    chk("rst_div", int'(div_active), 5);

    // Default divisor 5
    en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cyc();
      chk("def_out", int'(out), t1_out[k]);
      chk("def_tick", int'(tick), t1_tick[k]);
      chk("def_sq", int'(sq_out), t1_sq[k]);
    end

    // Enable gating at out=3
    cyc(); cyc(); cyc();
    chk("gate_pre_out", int'(out), 3);
    en = 1'b0;
    cyc(); chk("gate_hold_out", int'(out), 3); chk("gate_hold_tick", int'(tick), 0);
    chk("gate_hold_sq", int'(sq_out), 0);
    cyc(); chk("gate_hold2_out", int'(out), 3);
    en = 1'b1;
    cyc(); chk("gate_out4", int'(out), 4); chk("gate_tick4", int'(tick), 0);
    cyc(); chk("gate_wrap_out", int'(out), 0); chk("gate_wrap_tick", int'(tick), 1);
    cyc(); chk("gate_after_tick", int'(tick), 0); chk("gate_after_out", int'(out), 1);

    // Runtime reload to 3 at out=1
    div_load = 1'b1; div_val = 3'd3;
    cyc(); div_load = 1'b0;
    chk("rl_out2", int'(out), 2); chk("rl_div_old", int'(div_active), 5);
    cyc(); cyc();
    chk("rl_out4", int'(out), 4); chk("rl_div_old4", int'(div_active), 5);
    cyc(); chk("rl_wrap_div", int'(div_active), 3); chk("rl_wrap_sq", int'(sq_out), 1);
    cyc(); chk("rl_out1", int'(out), 1); chk("rl_sq1", int'(sq_out), 0);
    cyc(); chk("rl_out2b", int'(out), 2);
    cyc(); chk("rl_out0", int'(out), 0); chk("rl_tick", int'(tick), 1);

    // Load on the wrap edge goes straight to div_active
    cyc(); cyc();
    chk("we_pre", int'(out), 2);
    div_load = 1'b1; div_val = 3'd7;
    cyc(); div_load = 1'b0;
    chk("we_div7", int'(div_active), 7); chk("we_out0", int'(out), 0);
    for (int k = 1; k < 7; k++) begin
      cyc(); chk("we_cnt", int'(out), k);
    end
    cyc(); chk("we_wrap7", int'(out), 0); chk("we_tick7", int'(tick), 1);

    // Clamp: divisor 1 becomes 2 at the next wrap
    div_load = 1'b1; div_val = 3'd1;
    cyc(); div_load = 1'b0;
    chk("cl_div_hold", int'(div_active), 7);
    repeat (5) cyc();
    chk("cl_out6", int'(out), 6);
    cyc(); chk("cl_div2", int'(div_active), 2); chk("cl_out0", int'(out), 0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("cl_alt_out", int'(out), (k % 2 == 0) ? 1 : 0);
      chk("cl_alt_tick", int'(tick), (k % 2 == 1) ? 1 : 0);
    end

    // Clear priority with pending=6, active=7
    div_load = 1'b1; div_val = 3'd7;
    cyc(); div_load = 1'b0;
    cyc(); chk("clr_div7", int'(div_active), 7);
    cyc(); cyc();
    div_load = 1'b1; div_val = 3'd6;
    cyc(); div_load = 1'b0;
    chk("clr_pre_out", int'(out), 3);
    clr = 1'b1;
    cyc(); clr = 1'b0;
    chk("clr_out", int'(out), 0); chk("clr_tick", int'(tick), 0);
    chk("clr_sq", int'(sq_out), 0); chk("clr_div", int'(div_active), 6);
    repeat (5) cyc();
    chk("clr_out5", int'(out), 5);
    cyc(); chk("clr_wrap_tick", int'(tick), 1); chk("clr_wrap_sq", int'(sq_out), 1);

    // Async reset mid-period drops pending 7
    div_load = 1'b1; div_val = 3'd7;
    cyc(); div_load = 1'b0;
    cyc();
    chk("ar_pre_out", int'(out), 2); chk("ar_pre_sq", int'(sq_out), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_out", int'(out), 0); chk("ar_tick", int'(tick), 0);
    chk("ar_sq", int'(sq_out), 0); chk("ar_div", int'(div_active), 5);
    #3 rst_n = 1'b1;
    cyc(); chk("ar_rel_out", int'(out), 1); chk("ar_rel_div", int'(div_active), 5);
    repeat (4) cyc();
    chk("ar_wrap_out", int'(out), 0); chk("ar_wrap_div", int'(div_active), 5);
    chk("ar_wrap_tick", int'(tick), 1);
    repeat (3) cyc();

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
